// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer on the divided clock clk_out.
// Counts a programmed value down to zero, pulses done for one cycle at the
// terminal count and optionally reloads from the stored value to keep running.
module down_counter_timer #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_q;
  logic             reload_ok;

  // Reload only makes sense when enabled and a non-zero value is stored.
  always_comb begin
    reload_ok = (AUTO_RELOAD != 0) && (reload_q != '0);
  end

  // Busy decoded from the registered state.
  always_comb begin
    busy = (state == RUN) || (state == PAUSE);
  end

  // State, count, reload register and done pulse; priority load > start > pause > count.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out      <= '0;
      reload_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        out      <= load_val;
        reload_q <= load_val;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (out != '0) begin
                state <= RUN;
              end else begin
                done <= 1'b1;
              end
            end
          end
          RUN, PAUSE: begin
            if (pause) begin
              state <= PAUSE;
            end else begin
              // Leaving PAUSE counts on the same edge, so each paused
              // cycle costs exactly one extra edge.
              state <= RUN;
              if (out == '0) begin
                // Only reached on the edge after a terminal count.
                if (reload_ok) begin
                  out <= reload_q;
                end else begin
                  state <= IDLE;
                end
              end else if (out == WIDTH'(1)) begin
                out  <= '0;
                done <= 1'b1;
                if (!reload_ok) begin
                  state <= IDLE;
                end
              end else begin
                out <= out - WIDTH'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
